sm4_engine: RTL and testbench
=============================

Name: sm4_engine

Overview:
- Next-generation SM4 block-cipher core with a parametrised datapath: UNROLL rounds per clock (1/2/4/8) and a valid/ready streaming interface on input and output.
- Holds an expanded key schedule in a register file and encrypts or decrypts one 128-bit block at a time, selected per block.
- Sits between the host command/stream logic and the output buffer, replacing the fixed 1-round-per-cycle, command-driven core.

Parameters:
UNROLL, 1, number of cipher rounds per clock; legal values 1, 2, 4, 8; any other value is an elaboration error.
KEY_UNROLL, 1, number of key-expansion rounds per clock; legal values 1, 2, 4.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
key_vld  in  1  master key present
key_in  in  128  master key MK0..MK3, MK0 in [127:96]
key_rdy  out  1  core will accept key_in this cycle
key_ok  out  1  valid key schedule held
in_vld  in  1  input block present
in_rdy  out  1  core will accept a block this cycle
in_dec  in  1  0 = encrypt, 1 = decrypt; sampled with the block
in_data  in  128  input block, X0 in [127:96]
iv_vld  in  1  load chaining value (used only with SM4_CBC_EN)
iv_in  in  128  chaining value (used only with SM4_CBC_EN)
out_vld  out  1  result present
out_rdy  in  1  downstream accepts result
out_data  out  128  result block, Y0 in [127:96]
busy  out  1  state != IDLE

Behaviour:
- Reset: synchronous, sampled on the clk rising edge while rst_n=0.
  - State goes to IDLE. key_ok, out_vld and busy go to 0; out_data goes to 0.
  - Round keys are cleared; a schedule is never retained across reset.
  - A reset during KEYEXP, CRYPT or OUT aborts the operation with no output.
- States:
  - IDLE: key_rdy=1; in_rdy=key_ok.
    - key_vld=1 → load MK^FK into the key state and go to KEYEXP. key_ok drops to 0 on that edge.
    - key_vld and in_vld both high → the key wins; the block is not accepted.
    - in_vld & in_rdy → latch in_data and in_dec, set round counter=0, go to CRYPT.
  - KEYEXP: KEY_UNROLL rounds per cycle, using CK[i] and T' (L' = B^(B<<<13)^(B<<<23)). rk[i] is written to register-file entry i.
    - After 32/KEY_UNROLL cycles: key_ok=1 and return to IDLE.
  - CRYPT: UNROLL chained rounds per cycle with T (L = B^(B<<<2)^(B<<<10)^(B<<<18)^(B<<<24)).
    - Round-key index is n for encrypt and 31-n for decrypt.
    - The counter advances by UNROLL each cycle.
    - When the counter reaches 32-UNROLL, the next edge loads out_data with reversed words (X35,X34,X33,X32), sets out_vld=1, and goes to OUT.
  - OUT: out_data and out_vld hold stable until out_rdy=1. Then out_vld=0 and the state returns to IDLE; in_rdy is re-evaluated the following cycle.
- Handshakes:
  - No new block is accepted until the result has been taken (single block in flight).
  - key_vld and in_vld outside IDLE are ignored; key_rdy=in_rdy=0.
- Latency: a block accepted at edge t gives out_vld=1 visible after edge t+32/UNROLL.
  - UNROLL=1 → 32 cycles; 8 → 4 cycles.
  - Throughput is one block per 32/UNROLL+2 cycles with out_rdy held high.
- in_vld in IDLE with key_ok=0: in_rdy=0 and the block is held off, not dropped.
- Round-key reads: combinational from the register file, UNROLL words per cycle. No RAM inference is required.

Optional Feature:
- SM4_CBC_EN defined:
  - iv_vld in IDLE (lower priority than key_vld, higher than in_vld) loads the chain register from iv_in and consumes the cycle; in_rdy=0 that cycle.
  - Encrypt: the round input is in_data^chain; after the result, chain=out_data.
  - Decrypt: out_data = rounds(in_data)^chain; after the result, chain=in_data.
  - The chain register resets to 0.
- SM4_CBC_EN undefined:
  - iv_vld and iv_in are ignored; behaviour is pure ECB.
  - No chain register is synthesised; the ports remain so the interface is identical.

Test Plan:
- Key 0123456789abcdeffedcba9876543210: KEYEXP lasts 32/KEY_UNROLL cycles → key_ok=1, rk[0]=f12186f9, rk[31]=9124a012.
- Encrypt plaintext 0123456789abcdeffedcba9876543210, UNROLL=1,2,4,8 → out_data=681edf34d206965e86b3e94f536e4246; out_vld exactly 32/UNROLL cycles after accept.
- Decrypt 681edf34d206965e86b3e94f536e4246 → 0123456789abcdeffedcba9876543210.
- 1,000,000 chained encryptions of the same plaintext/key (UNROLL=8) → 595298c7c6fd271f0402f804c33d3f66.
- Backpressure: out_rdy=0 for 10 cycles → out_data stable, in_rdy=0; then out_rdy=1 → out_vld=0 next cycle, in_rdy=1 the cycle after.
- Reset mid-CRYPT (rst_n=0 one cycle at round 12) → IDLE, key_ok=0, out_vld never rises; in_vld is held off until a new key is loaded.
- (SM4_CBC_EN) IV=0, encrypt the test plaintext twice → second output equals ECB(681edf34…^plaintext); CBC decrypt of both ciphertexts recovers both plaintexts.

Source files
------------

// File: rtl/sm4_engine.sv
// SM4 block cipher: UNROLL rounds per clock, key schedule held in a register file, valid/ready streams.
// Optional CBC chaining is enabled by defining SM4_CBC_EN; the default build is pure ECB.
module sm4_engine #(
    parameter int UNROLL     = 1,
    parameter int KEY_UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_vld,
    input  logic [127:0] key_in,
    output logic         key_rdy,
    output logic         key_ok,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic         in_dec,
    input  logic [127:0] in_data,
    input  logic         iv_vld,
    input  logic [127:0] iv_in,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [127:0] out_data,
    output logic         busy
);

    generate
        if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
            $error("sm4_engine: UNROLL must be 1, 2, 4 or 8");
        end
        if (KEY_UNROLL != 1 && KEY_UNROLL != 2 && KEY_UNROLL != 4) begin : g_bad_key_unroll
            $error("sm4_engine: KEY_UNROLL must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };
    localparam logic [127:0] FK         = 128'ha3b1bac656aa3350677d9197b27022dc;
    localparam logic [5:0]   CRYPT_LAST = 6'(32 - UNROLL);
    localparam logic [5:0]   KEY_LAST   = 6'(32 - KEY_UNROLL);

    function automatic logic [31:0] rol(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    endfunction

    function automatic logic [31:0] t_crypt(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    // CK bytes follow (4i+j)*7 mod 256, so they are generated rather than tabulated.
    function automatic logic [31:0] ck(input logic [4:0] i);
        logic [31:0] r;
        r = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            r[31 - 8*j -: 8] = 8'((32'(i) * 4 + j) * 7);
        end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, KEYEXP, CRYPT, OUT} state_t;

    state_t       state, state_nx;
    logic [31:0]  rk [32];
    logic [127:0] kst, k_nx;
    logic [127:0] x, x_nx, crypt_res;
    logic [31:0]  krk [KEY_UNROLL];
    logic [31:0]  xw;
    logic [4:0]   ridx;
    logic [5:0]   cnt;
    logic         dec;
    logic         iv_take;
    logic [127:0] x_load, out_final;

    always_comb begin
        k_nx = kst;
        for (int unsigned j = 0; j < KEY_UNROLL; j++) begin
            krk[j] = k_nx[127:96] ^ t_key(k_nx[95:64] ^ k_nx[63:32] ^ k_nx[31:0] ^ ck(cnt[4:0] + 5'(j)));
            k_nx   = {k_nx[95:0], krk[j]};
        end
    end

    always_comb begin
        x_nx = x;
        xw   = '0;
        ridx = '0;
        for (int unsigned j = 0; j < UNROLL; j++) begin
            ridx = dec ? 5'd31 - (cnt[4:0] + 5'(j)) : cnt[4:0] + 5'(j);
            xw   = x_nx[127:96] ^ t_crypt(x_nx[95:64] ^ x_nx[63:32] ^ x_nx[31:0] ^ rk[ridx]);
            x_nx = {x_nx[95:0], xw};
        end
        crypt_res = {x_nx[31:0], x_nx[63:32], x_nx[95:64], x_nx[127:96]};
    end

`ifdef SM4_CBC_EN
    logic [127:0] chain, blk;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
            blk   <= '0;
        end else if (state == IDLE) begin
            if (!key_vld && iv_vld) begin
                chain <= iv_in;
            end else if (in_vld && in_rdy) begin
                blk <= in_data;
            end
        end else if (state == CRYPT && cnt == CRYPT_LAST) begin
            chain <= dec ? blk : crypt_res;
        end
    end

    assign iv_take   = iv_vld;
    assign x_load    = in_dec ? in_data : in_data ^ chain;
    assign out_final = dec ? crypt_res ^ chain : crypt_res;
`else
    logic unused_iv;

    assign unused_iv = ^{iv_vld, iv_in};
    assign iv_take   = 1'b0;
    assign x_load    = in_data;
    assign out_final = crypt_res;
`endif

    always_comb begin
        state_nx = state;
        key_rdy  = 1'b0;
        in_rdy   = 1'b0;
        case (state)
            IDLE: begin
                key_rdy = 1'b1;
                // a pending key or IV load takes the cycle, so the block is not offered as accepted
                in_rdy  = key_ok && !key_vld && !iv_take;
                if (key_vld) begin
                    state_nx = KEYEXP;
                end else if (in_vld && in_rdy) begin
                    state_nx = CRYPT;
                end
            end
            KEYEXP:  if (cnt == KEY_LAST) state_nx = IDLE;
            CRYPT:   if (cnt == CRYPT_LAST) state_nx = OUT;
            OUT:     if (out_rdy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            key_ok   <= 1'b0;
            out_vld  <= 1'b0;
            out_data <= '0;
            kst      <= '0;
            x        <= '0;
            cnt      <= '0;
            dec      <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) begin
                rk[i] <= '0;
            end
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (key_vld) begin
                        kst    <= key_in ^ FK;
                        cnt    <= '0;
                        key_ok <= 1'b0;
                    end else if (in_vld && in_rdy) begin
                        x   <= x_load;
                        dec <= in_dec;
                        cnt <= '0;
                    end
                end
                KEYEXP: begin
                    for (int unsigned j = 0; j < KEY_UNROLL; j++) begin
                        rk[cnt[4:0] + 5'(j)] <= krk[j];
                    end
                    kst <= k_nx;
                    cnt <= cnt + 6'(KEY_UNROLL);
                    if (cnt == KEY_LAST) key_ok <= 1'b1;
                end
                CRYPT: begin
                    x   <= x_nx;
                    cnt <= cnt + 6'(UNROLL);
                    if (cnt == CRYPT_LAST) begin
                        out_data <= out_final;
                        out_vld  <= 1'b1;
                    end
                end
                OUT: if (out_rdy) out_vld <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_engine.sv
// Self-checking bench for sm4_engine: randomized blocks checked against a word-array SM4 reference model.
module tb_sm4_engine;

    localparam int UNROLL     = 4;
    localparam int KEY_UNROLL = 2;
    localparam int NCYC       = 32 / UNROLL;
    localparam int KCYC       = 32 / KEY_UNROLL;
    localparam logic [127:0] KAT_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_PT  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_CT  = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] FK      = 128'ha3b1bac656aa3350677d9197b27022dc;
    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic         clk = 1'b0;
    logic         rst_n, key_vld, key_rdy, key_ok, in_vld, in_rdy, in_dec, iv_vld;
    logic         out_vld, out_rdy, busy;
    logic [127:0] key_in, in_data, iv_in, out_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0]  mrk [32];
    logic [127:0] mchain = '0;

    sm4_engine #(.UNROLL(UNROLL), .KEY_UNROLL(KEY_UNROLL)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_vld(key_vld), .key_in(key_in), .key_rdy(key_rdy), .key_ok(key_ok),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dec(in_dec), .in_data(in_data),
        .iv_vld(iv_vld), .iv_in(iv_in),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_sub(input logic [31:0] a);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[a[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] m_rotl(input logic [31:0] a, input int n);
        return (a << n) | (a >> (32 - n));
    endfunction

    function automatic logic [31:0] m_ck(input int i);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[31 - 8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
        return r;
    endfunction

    task automatic m_expand(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] b;
        for (int i = 0; i < 4; i++) k[i] = mk[127 - 32*i -: 32] ^ FK[127 - 32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            b = m_sub(k[i+1] ^ k[i+2] ^ k[i+3] ^ m_ck(i));
            k[i+4] = k[i] ^ b ^ m_rotl(b, 13) ^ m_rotl(b, 23);
            mrk[i] = k[i+4];
        end
    endtask

    function automatic logic [127:0] m_ecb(input logic [127:0] blk, input bit dec);
        logic [31:0] xa [36];
        logic [31:0] b;
        for (int i = 0; i < 4; i++) xa[i] = blk[127 - 32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            b = m_sub(xa[i+1] ^ xa[i+2] ^ xa[i+3] ^ (dec ? mrk[31 - i] : mrk[i]));
            xa[i+4] = xa[i] ^ b ^ m_rotl(b, 2) ^ m_rotl(b, 10) ^ m_rotl(b, 18) ^ m_rotl(b, 24);
        end
        return {xa[35], xa[34], xa[33], xa[32]};
    endfunction

    task automatic m_step(input logic [127:0] blk, input bit dec, output logic [127:0] exp);
`ifdef SM4_CBC_EN
        if (!dec) begin
            exp = m_ecb(blk ^ mchain, 1'b0);
            mchain = exp;
        end else begin
            exp = m_ecb(blk, 1'b1) ^ mchain;
            mchain = blk;
        end
`else
        exp = m_ecb(blk, dec);
`endif
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- drivers ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; key_vld = 1'b0; in_vld = 1'b0; iv_vld = 1'b0; out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mchain = '0;
    endtask

    task automatic load_key(input logic [127:0] k, output int lat);
        int g, t0;
        @(negedge clk);
        key_vld = 1'b1; key_in = k;
        g = 0;
        while (!key_rdy && g < 200) begin @(negedge clk); g++; end
        t0 = cyc;
        @(negedge clk);
        key_vld = 1'b0;
        g = 0;
        while (!key_ok && g < 200) begin @(negedge clk); g++; end
        lat = key_ok ? cyc - (t0 + 1) : -1;
        m_expand(k);
    endtask

    task automatic load_iv(input logic [127:0] v);
        @(negedge clk);
        iv_vld = 1'b1; iv_in = v;
        @(negedge clk);
        iv_vld = 1'b0;
`ifdef SM4_CBC_EN
        mchain = v;
`endif
    endtask

    task automatic do_block(input logic [127:0] d, input bit dec, input int hold,
                            output logic [127:0] res, output int lat);
        int g, t0;
        @(negedge clk);
        in_vld = 1'b1; in_data = d; in_dec = dec;
        g = 0;
        while (!in_rdy && g < 200) begin @(negedge clk); g++; end
        t0 = cyc;
        @(negedge clk);
        in_vld = 1'b0;
        g = 0;
        while (!out_vld && g < 200) begin @(negedge clk); g++; end
        lat = out_vld ? cyc - (t0 + 1) : -1;
        res = out_data;
        repeat (hold) @(negedge clk);
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if ({key_ok, out_vld, busy, key_rdy, in_rdy} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00010", {key_ok, out_vld, busy, key_rdy, in_rdy});
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
    endtask

    task automatic test_no_key_holdoff();
        int bad = 0;
        in_vld = 1'b1; in_data = KAT_PT; in_dec = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (in_rdy !== 1'b0 || busy !== 1'b0) bad++;
        end
        in_vld = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_key_holdoff: got %0d cycles accepting, expected 0", bad);
        end
    endtask

    task automatic test_keyexp();
        int lat, bad;
        load_key(KAT_KEY, lat);
        checks++;
        if (lat != KCYC) begin
            errors++;
            $display("FAIL keyexp_latency: got %0d expected %0d", lat, KCYC);
        end
        checks++;
        if (dut.rk[0] !== 32'hf12186f9) begin
            errors++;
            $display("FAIL rk0: got %h expected f12186f9", dut.rk[0]);
        end
        checks++;
        if (dut.rk[31] !== 32'h9124a012) begin
            errors++;
            $display("FAIL rk31: got %h expected 9124a012", dut.rk[31]);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (dut.rk[i] !== mrk[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rk_schedule: got %0d wrong entries expected 0", bad);
        end
    endtask

    task automatic test_kat();
        logic [127:0] res, exp;
        int lat;
        load_iv('0);
        m_step(KAT_PT, 1'b0, exp);
        do_block(KAT_PT, 1'b0, 0, res, lat);
        checks++;
        if (res !== KAT_CT) begin
            errors++;
            $display("FAIL kat_encrypt: got %h expected %h", res, KAT_CT);
        end
        checks++;
        if (lat != NCYC) begin
            errors++;
            $display("FAIL kat_latency: got %0d expected %0d", lat, NCYC);
        end
        load_iv('0);
        m_step(KAT_CT, 1'b1, exp);
        do_block(KAT_CT, 1'b1, 2, res, lat);
        checks++;
        if (res !== KAT_PT || lat != NCYC) begin
            errors++;
            $display("FAIL kat_decrypt: got %h/%0d expected %h/%0d", res, lat, KAT_PT, NCYC);
        end
    endtask

    task automatic test_key_priority();
        int g;
        bit saw_out = 1'b0;
        @(negedge clk);
        key_vld = 1'b1; key_in = KAT_KEY; in_vld = 1'b1; in_data = KAT_PT; in_dec = 1'b0;
        #1;
        checks++;
        if (in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL key_priority_in_rdy: got %b expected 0", in_rdy);
        end
        @(negedge clk);
        key_vld = 1'b0; in_vld = 1'b0;
        checks++;
        if ({busy, key_ok} !== 2'b10) begin
            errors++;
            $display("FAIL key_priority_state: got busy/key_ok %b expected 10", {busy, key_ok});
        end
        g = 0;
        while (!key_ok && g < 200) begin
            @(negedge clk); g++;
            if (out_vld) saw_out = 1'b1;
        end
        repeat (4) begin
            @(negedge clk);
            if (out_vld || busy) saw_out = 1'b1;
        end
        checks++;
        if (!key_ok || saw_out) begin
            errors++;
            $display("FAIL key_priority_block_dropped: got key_ok=%b out_seen=%b expected 1/0", key_ok, saw_out);
        end
        m_expand(KAT_KEY);
    endtask

    task automatic test_backpressure();
        logic [127:0] d, exp;
        int g;
        d = rnd128();
        m_step(d, 1'b0, exp);
        @(negedge clk);
        in_vld = 1'b1; in_data = d; in_dec = 1'b0;
        g = 0;
        while (!in_rdy && g < 200) begin @(negedge clk); g++; end
        @(negedge clk);
        in_vld = 1'b0;
        g = 0;
        while (!out_vld && g < 200) begin @(negedge clk); g++; end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({out_vld, in_rdy} !== 2'b10 || out_data !== exp) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got vld/rdy %b data %h expected 10 %h",
                         i, {out_vld, in_rdy}, out_data, exp);
            end
            @(negedge clk);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        checks++;
        if (out_vld !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: got out_vld %b expected 0", out_vld);
        end
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_in_rdy: got %b expected 1", in_rdy);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp;
        int g, acc, prev;
        prev = 0;
        @(negedge clk);
        out_rdy = 1'b1; in_vld = 1'b1; in_data = rnd128(); in_dec = 1'($urandom_range(0, 1));
        for (int i = 0; i < 5; i++) begin
            g = 0;
            while (!in_rdy && g < 200) begin @(negedge clk); g++; end
            acc = cyc;
            if (i > 0) begin
                checks++;
                if (acc - prev != NCYC + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, acc - prev, NCYC + 2);
                end
            end
            prev = acc;
            m_step(in_data, in_dec, exp);
            @(negedge clk);
            in_data = rnd128(); in_dec = 1'($urandom_range(0, 1));
            g = 0;
            while (!out_vld && g < 200) begin @(negedge clk); g++; end
            checks++;
            if (out_vld !== 1'b1 || out_data !== exp) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %h expected %h", i, out_data, exp);
            end
            @(negedge clk);
        end
        in_vld = 1'b0; out_rdy = 1'b0;
    endtask

    task automatic test_chained();
        logic [127:0] blk, res, exp;
        int lat;
        load_iv('0);
        blk = KAT_PT;
        for (int i = 0; i < 4; i++) begin
            m_step(blk, 1'b0, exp);
            do_block(blk, 1'b0, 0, res, lat);
            checks++;
            if (res !== exp) begin
                errors++;
                $display("FAIL chained[%0d]: got %h expected %h", i, res, exp);
            end
            blk = res;
        end
    endtask

    task automatic test_random();
        logic [127:0] d, res, exp;
        bit dec;
        int lat;
        for (int n = 0; n < 12; n++) begin
            if (n % 4 == 0) begin
                load_key(rnd128(), lat);
                checks++;
                if (lat != KCYC) begin
                    errors++;
                    $display("FAIL random_key_latency[%0d]: got %0d expected %0d", n, lat, KCYC);
                end
            end
            if ($urandom_range(0, 2) == 0) load_iv(rnd128());
            d = rnd128();
            dec = 1'($urandom_range(0, 1));
            m_step(d, dec, exp);
            do_block(d, dec, int'($urandom_range(0, 3)), res, lat);
            checks++;
            if (res !== exp || lat != NCYC) begin
                errors++;
                $display("FAIL random_block[%0d]: got %h/%0d expected %h/%0d", n, res, lat, exp, NCYC);
            end
        end
    endtask

    task automatic test_reset_mid_crypt();
        logic [127:0] res, exp;
        int g, lat, bad;
        @(negedge clk);
        in_vld = 1'b1; in_data = rnd128(); in_dec = 1'b0;
        g = 0;
        while (!in_rdy && g < 200) begin @(negedge clk); g++; end
        @(negedge clk);
        in_vld = 1'b0;
        repeat (12 / UNROLL) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mchain = '0;
        checks++;
        if ({busy, key_ok, out_vld} !== 3'b000 || out_data !== '0) begin
            errors++;
            $display("FAIL midreset_state: got busy/key_ok/out_vld %b data %h expected 000 0",
                     {busy, key_ok, out_vld}, out_data);
        end
        in_vld = 1'b1;
        bad = 0;
        repeat (NCYC + 8) begin
            @(negedge clk);
            if (out_vld || in_rdy || busy) bad++;
        end
        in_vld = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_holdoff: got %0d active cycles expected 0", bad);
        end
        load_key(KAT_KEY, lat);
        m_step(KAT_PT, 1'b0, exp);
        do_block(KAT_PT, 1'b0, 0, res, lat);
        checks++;
        if (res !== KAT_CT || lat != NCYC) begin
            errors++;
            $display("FAIL midreset_recover: got %h/%0d expected %h/%0d", res, lat, KAT_CT, NCYC);
        end
    endtask

`ifdef SM4_CBC_EN
    task automatic test_cbc();
        logic [127:0] c1, c2, p1, p2, exp;
        int lat;
        load_iv('0);
        m_step(KAT_PT, 1'b0, exp);
        do_block(KAT_PT, 1'b0, 0, c1, lat);
        m_step(KAT_PT, 1'b0, exp);
        do_block(KAT_PT, 1'b0, 0, c2, lat);
        checks++;
        if (c1 !== KAT_CT || c2 !== m_ecb(KAT_CT ^ KAT_PT, 1'b0)) begin
            errors++;
            $display("FAIL cbc_encrypt: got %h %h expected %h %h", c1, c2, KAT_CT, m_ecb(KAT_CT ^ KAT_PT, 1'b0));
        end
        load_iv('0);
        m_step(c1, 1'b1, exp);
        do_block(c1, 1'b1, 0, p1, lat);
        m_step(c2, 1'b1, exp);
        do_block(c2, 1'b1, 0, p2, lat);
        checks++;
        if (p1 !== KAT_PT || p2 !== KAT_PT) begin
            errors++;
            $display("FAIL cbc_decrypt: got %h %h expected %h", p1, p2, KAT_PT);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; key_vld = 1'b0; key_in = '0; in_vld = 1'b0; in_dec = 1'b0;
        in_data = '0; iv_vld = 1'b0; iv_in = '0; out_rdy = 1'b0;
        apply_reset();
        test_reset();
        test_no_key_holdoff();
        test_keyexp();
        test_kat();
        test_key_priority();
        test_backpressure();
        test_back_to_back();
        test_chained();
        test_random();
        test_reset_mid_crypt();
`ifdef SM4_CBC_EN
        test_cbc();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
